// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo push arbiter.
//   state_t    : controller state encoding (IDLE, ISSUE, SETTLE, WAIT, ACK)
//   DATA_W_DEF : default producer / fifo data width
//   clog2      : index width helper usable in parameter and port declarations
package fifo_arb_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } state_t;

  // Smallest r with 2**r >= v; returns at least 1 so a 1-bit index always exists.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req    : per-requester request vector
//   ptr    : index with highest priority this round
//   winner : first set request at or above ptr, wrapping to the bottom
//   any    : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] src;

  always_comb begin
    // Requests at or above ptr take precedence; if none, fall back to the
    // full vector, which gives the wrap-around half of the scan.
    hi_mask = ~((N'(1) << ptr) - N'(1));
    hi_req  = req & hi_mask;
    src     = (|hi_req) ? hi_req : req;
    any     = |req;
    winner  = '0;
    // Lowest set bit of src; scanning downward lets the lowest index win.
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) winner = IW'(i);
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin write controller sharing one fifo write port among N producers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req / req_data      : per-producer request and flattened data slices
//   ack / err           : one-cycle completion pulse (err marks a busy timeout)
//   grant_id / active   : current or last granted producer, transaction in flight
//   fifo_full/fifo_busy : fifo status inputs
//   fifo_push/fifo_data : one-cycle push strobe and registered push data
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*DATA_W-1:0]   req_data,
  output logic [N-1:0]          ack,
  output logic                  err,
  output logic [clog2(N)-1:0]   grant_id,
  output logic                  active,
  input  logic                  fifo_full,
  input  logic                  fifo_busy,
  output logic                  fifo_push,
  output logic [DATA_W-1:0]     fifo_data
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, nxt;
  logic [IW-1:0] ptr, winner;
  logic          any, grant, ack_d, err_d, active_d;
  logic [CW-1:0] cnt;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any && !fifo_full && !fifo_busy) nxt = ISSUE;
      ISSUE:   nxt = SETTLE;
      // The fifo raises busy in response to the push, so one cycle is
      // skipped before busy is trusted.
      SETTLE:  nxt = WAIT;
      WAIT:    if (!fifo_busy || cnt == CNT_LAST) nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    grant    = (state == IDLE) && (nxt == ISSUE);
    ack_d    = (state == WAIT) && (nxt == ACK);
    // Leaving WAIT while busy is still high can only be the timeout path.
    err_d    = ack_d && fifo_busy;
    active_d = grant || (active && (state != ACK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      grant_id  <= '0;
      fifo_data <= '0;
      fifo_push <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      active    <= 1'b0;
      cnt       <= '0;
    end else begin
      fifo_push <= grant;
      ack       <= ack_d ? (N'(1) << grant_id) : '0;
      err       <= err_d;
      active    <= active_d;
      // Counts busy cycles inside WAIT; zero everywhere else.
      cnt       <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (grant) begin
        grant_id  <= winner;
        fifo_data <= req_data[int'(winner)*DATA_W +: DATA_W];
        ptr       <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic            err;
  logic [1:0]      grant_id;
  logic            active;
  logic            fifo_full = 1'b0;
  logic            fifo_busy = 1'b0;
  logic            fifo_push;
  logic [DW-1:0]   fifo_data;

  fifo_push_arbiter #(.N(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .err       (err),
    .grant_id  (grant_id),
    .active    (active),
    .fifo_full (fifo_full),
    .fifo_busy (fifo_busy),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- stimulus: producers, fifo busy/full stub ----------------
  bit rand_en = 1'b0;
  bit stop_new = 1'b0;
  int b_force = -1;   // >=0 fixes busy length after each push
  int busy_left = 0;
  int last_b = 0;     // busy length chosen for the most recent push

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left = 0;
      fifo_busy = 1'b0;
    end else begin
      // fifo stub: busy high for last_b cycles starting the cycle after a push
      if (fifo_push) begin
        last_b = (b_force >= 0) ? b_force : (($urandom % 8 == 0) ? 20 : int'($urandom % 4));
        busy_left = last_b;
        fifo_busy = 1'b0;
      end else begin
        fifo_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end
      req = req & ~ack;
      if (rand_en) begin
        fifo_full = ($urandom % 6 == 0);
        for (int i = 0; i < N; i++) begin
          if (!req[i] && !ack[i] && !stop_new && ($urandom % 3 == 0)) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = 8'($urandom);
          end else if (req[i] && ($urandom % 4 == 0)) begin
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end
      end else begin
        fifo_full = 1'b0;
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct { int id; bit e; int cyc; } exp_t;
  exp_t sb[$];

  int              cyc = 0;
  int              ptr_m = 0;
  bit              open = 1'b0, prev_idle = 1'b1, prev_full = 1'b0, prev_busy = 1'b0;
  logic [N-1:0]    prev_req = '0;
  logic [N*DW-1:0] prev_data = '0;
  bit              exp_push, in_this;
  int              w, k0;
  exp_t            e;

  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ptr_m = 0; sb.delete(); open = 1'b0; prev_idle = 1'b1;
      prev_req = '0; prev_full = 1'b0; prev_busy = 1'b0;
    end else begin
      cyc++;
      // A grant happens on an idle cycle with a request and a ready fifo;
      // the push is seen one cycle later.
      exp_push = prev_idle && (|prev_req) && !prev_full && !prev_busy;
      chk("push", 32'(fifo_push), 32'(exp_push));
      if (fifo_push && exp_push) begin
        w = rr_model(prev_req, ptr_m);
        ptr_m = (w + 1) % N;
        chk("grant_id", 32'(grant_id), w);
        chk("fifo_data", 32'(fifo_data), 32'(prev_data[w*DW +: DW]));
        // WAIT starts two cycles after the push; busy covers push+1..push+last_b.
        k0 = (last_b > 1) ? last_b - 1 : 0;
        e.id = w;
        if (k0 <= TO - 1) begin e.e = 1'b0; e.cyc = cyc + 3 + k0; end
        else              begin e.e = 1'b1; e.cyc = cyc + 2 + TO; end
        sb.push_back(e);
        open = 1'b1;
      end
      in_this = open;
      chk("active", 32'(active), 32'(in_this));
      if (ack != '0 || err) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL ack_unexpected: ack=%b err=%b with no transaction pending", ack, err);
        end else begin
          e = sb.pop_front();
          chk("ack_id", 32'(ack), 32'(1) << e.id);
          chk("ack_err", 32'(err), 32'(e.e));
          chk("ack_cycle", cyc, e.cyc);
        end
        open = 1'b0;
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        checks++; failures++;
        $display("FAIL ack_missing: none at cycle %0d, expected for requester %0d", cyc, sb[0].id);
        void'(sb.pop_front());
        open = 1'b0;
      end
      prev_idle = !in_this;
      prev_req  = req;
      prev_data = req_data;
      prev_full = fifo_full;
      prev_busy = fifo_busy;
    end
  end

  // ---------------- sequence ----------------
  bit got;

  task automatic chk_quiet(input string tag);
    chk({tag, "_push"},   32'(fifo_push), 0);
    chk({tag, "_ack"},    32'(ack), 0);
    chk({tag, "_err"},    32'(err), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_gid"},    32'(grant_id), 0);
    chk({tag, "_data"},   32'(fifo_data), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Long busy so the transaction sits in WAIT, then reset mid-flight.
    b_force = 20;
    req[2] = 1'b1;
    req_data[2*DW +: DW] = 8'hF1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_push) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL push_timeout: no push within 20 cycles, required one"); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_quiet("midreset");
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    // Pointer must restart at 0: requester 2 wins over 3.
    b_force = 1;
    req[3] = 1'b1;
    req_data[3*DW +: DW] = 8'h33;
    repeat (30) @(posedge clk);

    b_force = -1;
    rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    stop_new = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0 || req != '0) begin
      failures++;
      $display("FAIL drain: pending=%0d req=%b, required 0 and 0000", sb.size(), req);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin write controller that shares one fifo write port between N producers.
- Accepts per-requester req/data and grants one requester at a time.
- Issues a single-cycle push with stable data, waits for the fifo's busy handshake to complete, then acks the requester.
- Sits directly in front of the 8-bit fifo. Pop side is untouched.

Parameters:
- N, 4, number of requesters (2..8).
- DATA_W, 8, data width; matches fifo data_in.
- TIMEOUT, 16, max cycles fifo_busy may stay high before the transaction is aborted with an error.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  request per producer; held high until ack.
- req_data  in  N*DATA_W  flattened data; slice i = req_data[i*DATA_W +: DATA_W].
- ack  out  N  one-cycle completion pulse to the granted producer.
- err  out  1  one-cycle pulse coincident with ack when the transaction timed out.
- grant_id  out  clog2(N)  index of the current or last granted producer.
- active  out  1  high from grant until ack (inclusive).
- fifo_full  in  1  fifo full flag.
- fifo_busy  in  1  fifo busy flag.
- fifo_push  out  1  one-cycle push pulse.
- fifo_data  out  DATA_W  data to fifo data_in, registered.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; rr pointer=0.
  - ack=0, err=0, fifo_push=0, fifo_data=0, grant_id=0, active=0, timeout counter=0.
  - A reset mid-transaction drops the transaction; no ack is issued.
- States:
  - IDLE -> ISSUE when |req && !fifo_full && !fifo_busy.
    - Winner is the first set req scanning from ptr upward, mod N.
    - Registers: grant_id=winner, fifo_data=req_data slice, active=1, ptr=(winner+1) mod N.
    - If the condition is false, stay in IDLE; no grant.
  - ISSUE (1 cycle): fifo_push=1; fifo_data stable. -> SETTLE.
  - SETTLE (1 cycle): fifo_busy ignored; counter cleared. -> WAIT.
  - WAIT:
    - fifo_busy=0 -> ACK.
    - Otherwise counter++.
    - Counter reaching TIMEOUT-1 while busy -> ACK with err flagged.
  - ACK (1 cycle): ack[grant_id]=1; err=1 if timed out; active=1. -> IDLE; active=0 next cycle.
- Latency: req seen in IDLE at cycle 0 -> push at cycle 1 -> ack at cycle 4 minimum (busy low on first WAIT cycle).
- Throughput: one transaction per 5 cycles minimum. IDLE is re-entered for one cycle before the next grant.
- Data is latched at grant. Changing req_data or dropping req after the grant does not affect the transaction.
- Requester must deassert req on the cycle after ack. A req still high in IDLE is treated as a new request.
- fifo_full rising after grant does not cancel the push; the fifo owns overflow handling.
- Simultaneous requests: strict round-robin, so no requester waits more than N-1 grants.
- All outputs are registered; no combinational path from req to fifo_push.
- grant_id holds its last value while IDLE.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding constants IDLE=0, ISSUE=1, SETTLE=2, WAIT=3, ACK=4 (3-bit).
  - default DATA_W.
  - clog2 function.
- Sub-module rr_pick: combinational round-robin picker with inputs req[N], ptr and outputs winner, any. The FSM, registers and timeout counter stay in fifo_push_arbiter.

Test Plan:
- Reset with req=4'b0001, req_data slice0=8'hF1 -> after release: fifo_push at cycle 1, fifo_data=8'hF1, ack=4'b0001 at cycle 4 (busy stubbed 1 cycle high after push); err=0.
- req=4'b1111, data 8'hA0..8'hA3, held until each ack -> push order A0,A1,A2,A3, then A0 again if reqs are re-raised; grant_id sequence 0,1,2,3.
- fifo_full=1 with req=4'b0100 -> no fifo_push, active=0; drop full -> grant to requester 2 next cycle, data pushed.
- fifo_busy held high 20 cycles after push, TIMEOUT=16 -> ack and err pulse together 16 WAIT cycles in; next grant proceeds normally.
- reset asserted in WAIT -> fifo_push=0, active=0, ack=0 immediately; ptr=0 after release; the aborted requester is regranted first.
- req_data changed to 8'hFA one cycle after grant of 8'hF1 -> fifo_data stays 8'hF1 through ACK.
